// File: rtl/debug_reg_snapshot.sv
// Debug readout for the ID-stage register file: registered single-register reads
// from the live bus or a frozen snapshot, plus an auto-scan walker for the display path.
`timescale 1ns/1ps

module debug_reg_snapshot #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned ZERO_REG0 = 1,
    parameter int unsigned SCAN_HOLD = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REGS*DATA_W-1:0]   debug_id_registers,
    input  logic                         snap_req,
    output logic                         snap_done,
    output logic                         snap_valid,
    input  logic                         rd_req,
    input  logic                         rd_src,
    input  logic [ADDR_W-1:0]            debug_addr,
    output logic [DATA_W-1:0]            debug_data_reg,
    output logic                         rd_valid,
    output logic                         addr_err,
    input  logic                         scan_en,
    output logic [ADDR_W-1:0]            scan_addr,
    output logic [DATA_W-1:0]            scan_data,
    output logic                         scan_wrap
);

    localparam int unsigned BUS_W   = NUM_REGS * DATA_W;
    localparam int unsigned VIEW_N  = 2 ** ADDR_W;
    localparam int unsigned HOLD_W  = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_HOLD - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_REGS - 1);
    localparam bit   ZERO_R0  = (ZERO_REG0 != 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } scan_state_t;

    // Shadow copy of the whole register bus, kept flat like the input.
    logic [BUS_W-1:0]  shadow;

    // Address-indexed views padded to the full address space; unused slots read 0.
    logic [DATA_W-1:0] live_view   [VIEW_N];
    logic [DATA_W-1:0] shadow_view [VIEW_N];

    // Read-path combinational selection.
    logic              rd_oob_c;
    logic [DATA_W-1:0] rd_sel_c;

    // Scan FSM state and next-state values.
    scan_state_t       state;
    scan_state_t       state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [ADDR_W-1:0] scan_addr_nxt;
    logic [DATA_W-1:0] scan_data_nxt;
    logic              scan_wrap_nxt;
    logic [DATA_W-1:0] scan_live_c;

    // Slice the flat buses into per-address views.
    for (genvar g = 0; g < VIEW_N; g++) begin : g_view
        if (g < NUM_REGS) begin : g_in
            assign live_view[g]   = debug_id_registers[g*DATA_W +: DATA_W];
            assign shadow_view[g] = shadow[g*DATA_W +: DATA_W];
        end else begin : g_out
            assign live_view[g]   = '0;
            assign shadow_view[g] = '0;
        end
    end

    // Capture the full register bus on a snapshot request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (snap_req) begin
            shadow <= debug_id_registers;
        end
    end

    // Snapshot handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_done  <= 1'b0;
            snap_valid <= 1'b0;
        end else begin
            snap_done  <= snap_req;
            snap_valid <= snap_valid | snap_req;
        end
    end

    // Pick the read value: out-of-range and register 0 read as zero.
    always_comb begin
        rd_oob_c = (32'(debug_addr) >= NUM_REGS);
        rd_sel_c = rd_src ? shadow_view[debug_addr] : live_view[debug_addr];
        if (rd_oob_c) begin
            rd_sel_c = '0;
        end else if (ZERO_R0 && (debug_addr == '0)) begin
            rd_sel_c = '0;
        end
    end

    // Registered read response; data holds when no read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            debug_data_reg <= '0;
            rd_valid       <= 1'b0;
            addr_err       <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            addr_err <= rd_req & rd_oob_c;
            if (rd_req) begin
                debug_data_reg <= rd_sel_c;
            end
        end
    end

    // Live value of the register under scan, with register 0 forced to zero.
    always_comb begin
        scan_live_c = live_view[scan_addr];
        if (ZERO_R0 && (scan_addr == '0)) begin
            scan_live_c = '0;
        end
    end

    // Scan FSM state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            scan_addr <= '0;
            scan_data <= '0;
            scan_wrap <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            scan_addr <= scan_addr_nxt;
            scan_data <= scan_data_nxt;
            scan_wrap <= scan_wrap_nxt;
        end
    end

    // Scan FSM next-state: hold each register SCAN_HOLD cycles, wrap at NUM_REGS.
    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold_cnt;
        scan_addr_nxt = scan_addr;
        scan_data_nxt = scan_data;
        scan_wrap_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                hold_nxt      = '0;
                scan_addr_nxt = '0;
                scan_data_nxt = '0;
                if (scan_en) begin
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!scan_en) begin
                    state_nxt     = S_IDLE;
                    hold_nxt      = '0;
                    scan_addr_nxt = '0;
                    scan_data_nxt = '0;
                end else begin
                    scan_data_nxt = scan_live_c;
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt = '0;
                        if (scan_addr == ADDR_LAST) begin
                            scan_addr_nxt = '0;
                            scan_wrap_nxt = 1'b1;
                        end else begin
                            scan_addr_nxt = scan_addr + ADDR_W'(1);
                        end
                    end else begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_nxt     = S_IDLE;
                hold_nxt      = '0;
                scan_addr_nxt = '0;
                scan_data_nxt = '0;
            end
        endcase
    end

endmodule

// File: doc/debug_reg_snapshot.md
Name: debug_reg_snapshot

Overview:
Parametrised debug readout for the ID-stage register file. Takes the flattened register bus and serves single-register reads with one cycle of latency, either from the live registers or from a frozen snapshot. Also provides an auto-scan mode that walks every register in turn for the board display path. Sits between the ID stage and the debug/VGA display logic.

Parameters:
DATA_W, 32, width of one register
NUM_REGS, 32, number of registers in the flattened bus (>=2)
ADDR_W, 5, address width; must satisfy 2^ADDR_W >= NUM_REGS
ZERO_REG0, 1, when 1, reads of register 0 always return 0
SCAN_HOLD, 4, cycles each register is held in scan mode (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
debug_id_registers  in  NUM_REGS*DATA_W  flattened register file; reg i occupies bits [DATA_W*i+DATA_W-1 : DATA_W*i]
snap_req  in  1  single-cycle request to capture all registers into the shadow array
snap_done  out  1  one-cycle pulse, the cycle after the capture
snap_valid  out  1  high once any snapshot has been taken since reset
rd_req  in  1  read strobe
rd_src  in  1  0 = live registers, 1 = snapshot
debug_addr  in  ADDR_W  read address
debug_data_reg  out  DATA_W  read data, registered
rd_valid  out  1  one-cycle pulse qualifying debug_data_reg
addr_err  out  1  one-cycle pulse with rd_valid when debug_addr >= NUM_REGS
scan_en  in  1  level; enables auto-scan
scan_addr  out  ADDR_W  register currently scanned
scan_data  out  DATA_W  live value of scan_addr, registered
scan_wrap  out  1  one-cycle pulse when scan_addr wraps from NUM_REGS-1 to 0

Behaviour:
- Reset (async, rst=1): all outputs 0, the shadow array cleared to 0, and the scan FSM set to IDLE with the hold counter at 0. Reset takes effect immediately, including mid-scan or in a snap_req cycle.
- Read path: when rd_req=1 at edge N, at edge N+1 debug_data_reg holds the selected value and rd_valid=1. When rd_req=0, rd_valid=0 and debug_data_reg holds its last value.
- Selected value:
  - If debug_addr >= NUM_REGS: returns 0 and addr_err=1.
  - Else if ZERO_REG0=1 and debug_addr=0: returns 0, regardless of rd_src.
  - Else rd_src selects live registers (rd_src=0) or the shadow array (rd_src=1).
  - A snapshot read before any capture returns 0 (the shadow array reset value).
- Snapshot: on snap_req=1 at edge N, the whole input bus is copied into the shadow array at edge N. snap_done=1 and snap_valid=1 are seen after edge N, and snap_done clears after edge N+1.
- Same-cycle snapshot and read: a snapshot read in the same cycle as snap_req returns the pre-capture shadow contents. Back-to-back snap_req each recapture, and snap_done stays high for those consecutive cycles.
- Scan FSM, IDLE -> SCAN: when scan_en=1 in IDLE, the next edge enters SCAN with scan_addr=0 and hold counter=0.
- Scan FSM, in SCAN:
  - Every edge, scan_data is loaded with the live value of scan_addr; the ZERO_REG0 rule applies.
  - The hold counter increments each edge. At SCAN_HOLD-1 it clears to 0 and scan_addr advances by 1.
  - At NUM_REGS-1, scan_addr advances to 0 instead and scan_wrap pulses for one cycle.
  - Wrap uses NUM_REGS, not 2^ADDR_W.
- Scan FSM, SCAN -> IDLE: scan_en=0 returns to IDLE at the next edge, clearing scan_addr, the hold counter and scan_data. Re-enabling always restarts at register 0.
- The read path and scan path are independent and may be active in the same cycle.
- Width rules: all address comparisons are unsigned at ADDR_W bits. Part-select indexing is computed at full width, with no truncation of DATA_W*addr.

Test Plan:
- Reset, then hold rst=1 for 3 cycles mid-scan → all outputs 0. After release with scan_en=0, scan_addr stays 0.
- Load reg5=0xDEADBEEF, rd_req=1, rd_src=0, debug_addr=5 → next cycle debug_data_reg=0xDEADBEEF, rd_valid=1, addr_err=0. Same sequence with debug_addr=0 and reg0=0x12345678 → returns 0.
- NUM_REGS=24, debug_addr=30, rd_req=1 → next cycle debug_data_reg=0, rd_valid=1, addr_err=1.
- Sequence:
  - reg3=0x11, snap_req → snap_done pulse, snap_valid=1.
  - Change reg3=0x22.
  - Read rd_src=1, addr 3 → returns 0x11.
  - Read rd_src=0, addr 3 → returns 0x22.
  - Repeat with snap_req and the read in the same cycle → returns 0x11, and the following snapshot read returns 0x22.
- scan_en=1, SCAN_HOLD=4, NUM_REGS=32 → scan_addr changes every 4 cycles over 0..31. scan_wrap pulses exactly once per 128 cycles, on the cycle scan_addr returns to 0.
- Drop scan_en at scan_addr=17, then re-raise → FSM returns to IDLE with scan_addr=0, then restarts at 0 with a fresh 4-cycle hold.
